rotate_pulse_gen: RTL and testbench

Front-end for the rotate button. It synchronises and debounces the raw push-button and produces clean, fixed-width rotate strobes, with auto-repeat while the button is held. Its rotate output drives the rotate input of the piece-orientation counter, which advances on each rising edge, so exactly one rising edge is emitted per intended rotation. It sits between the board pin and the orientation counter / game logic.

---
 rtl/rotate_pulse_gen.sv | 151 +++++++++++++++
 tb/tb_rotate_pulse_gen.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rotate_pulse_gen.sv
// Rotate button front-end: synchronises and debounces the raw button, then emits
// fixed-width rotate strobes with auto-repeat while the button stays held.
module rotate_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 30000000,
    parameter int REPEAT_PERIOD   = 15000000,
    parameter int PULSE_WIDTH     = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    input  logic enable,
    output logic rotate,
    output logic pressed,
    output logic repeat_active
);

    localparam int MAX_AB  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int CNT_MAX = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int PW_W    = $clog2(PULSE_WIDTH + 1);

    localparam logic [CW-1:0]   DEB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]   DELAY_LAST  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0]   PERIOD_LAST = CW'(REPEAT_PERIOD - 1);
    localparam logic [PW_W-1:0] PULSE_LOAD  = PW_W'(PULSE_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        DEB_PRESS,
        HOLD_DELAY,
        REPEAT,
        DEB_RELEASE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_next;
    logic            s1;
    logic            btn_s;
    logic            fire;
    logic            pressed_next;
    logic [PW_W-1:0] pulse_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1    <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            s1    <= btn_raw;
            btn_s <= s1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            pressed       <= 1'b0;
            repeat_active <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            pressed       <= pressed_next;
            repeat_active <= (state_next == REPEAT);
        end
    end

    // The shared counter restarts on every state change; release bounce returns
    // to HOLD_DELAY silently so it can never produce an extra strobe.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        fire         = 1'b0;
        pressed_next = pressed;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (btn_s) state_next = DEB_PRESS;
            end
            DEB_PRESS: begin
                if (!btn_s) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_next   = HOLD_DELAY;
                    cnt_next     = '0;
                    pressed_next = 1'b1;
                    fire         = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            HOLD_DELAY: begin
                if (!btn_s) begin
                    state_next = DEB_RELEASE;
                    cnt_next   = '0;
                end else if (cnt == DELAY_LAST) begin
                    state_next = REPEAT;
                    cnt_next   = '0;
                    fire       = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            REPEAT: begin
                if (!btn_s) begin
                    state_next = DEB_RELEASE;
                    cnt_next   = '0;
                end else if (cnt == PERIOD_LAST) begin
                    cnt_next = '0;
                    fire     = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            DEB_RELEASE: begin
                if (btn_s) begin
                    state_next = HOLD_DELAY;
                    cnt_next   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_next   = IDLE;
                    cnt_next     = '0;
                    pressed_next = 1'b0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // A running pulse always completes its full width and ignores new fires.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rotate    <= 1'b0;
            pulse_cnt <= '0;
        end else if (rotate) begin
            if (pulse_cnt == '0) rotate <= 1'b0;
            else                 pulse_cnt <= pulse_cnt - 1'b1;
        end else if (fire && enable) begin
            rotate    <= 1'b1;
            pulse_cnt <= PULSE_LOAD;
        end
    end

endmodule

// File: tb/tb_rotate_pulse_gen.sv
// Bench for rotate_pulse_gen: directed scenarios plus randomised bouncy presses,
// all checked every cycle against a run-length/timestamp model of the button.
module tb_rotate_pulse_gen;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 5;
    localparam int PW = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_raw = 1'b0;
    logic enable = 1'b1;
    logic rotate;
    logic pressed;
    logic repeat_active;

    rotate_pulse_gen #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP),
        .PULSE_WIDTH(PW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_raw(btn_raw),
        .enable(enable),
        .rotate(rotate),
        .pressed(pressed),
        .repeat_active(repeat_active)
    );

    always #5 clk = ~clk;

    // Orientation counter (five orientations) advancing on each rotate rising edge
    logic [2:0] orient;
    logic       rot_q;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            orient <= 3'd0;
            rot_q  <= 1'b0;
        end else begin
            rot_q <= rotate;
            if (rotate && !rot_q) orient <= (orient == 3'd4) ? 3'd0 : orient + 3'd1;
        end
    end

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int k = 0;
    int hi_cnt = 0;
    int fall_cyc = -1;
    int rises[$];
    logic prev_rot = 1'b0;
    logic prev_pr = 1'b0;

    // Model: what the debouncer sees is btn_raw two edges late; presses need D+1
    // consecutive high samples, releases D+1 consecutive low samples, and strobes
    // fall at RD, RD+RP, RD+2RP... samples after the hold started.
    bit m_hist0, m_hist1;
    bit m_level;
    bit m_rep;
    int m_ones, m_zeros, m_hold, m_rem;

    task automatic modelReset();
        m_hist0 = 0; m_hist1 = 0; m_level = 0; m_rep = 0;
        m_ones = 0; m_zeros = 0; m_hold = 0; m_rem = 0;
        prev_rot = 1'b0; prev_pr = 1'b0;
    endtask

    task automatic modelStep();
        bit b;
        bit fire;
        b = m_hist1;
        fire = 0;
        m_hist1 = m_hist0;
        m_hist0 = btn_raw;
        if (!m_level) begin
            m_rep = 0;
            if (b) begin
                m_ones++;
                if (m_ones == D + 1) begin
                    m_level = 1; m_ones = 0; m_hold = 0; m_zeros = 0; fire = 1;
                end
            end else begin
                m_ones = 0;
            end
        end else if (b) begin
            if (m_zeros > 0) begin
                m_zeros = 0;
                m_hold = 0;
            end else begin
                m_hold++;
                fire = (m_hold >= RD) && (((m_hold - RD) % RP) == 0);
            end
            m_rep = (m_hold >= RD);
        end else begin
            m_rep = 0;
            m_zeros++;
            if (m_zeros == D + 1) begin
                m_level = 0; m_zeros = 0; m_ones = 0;
            end
        end
        if (m_rem > 0) m_rem--;
        else if (fire && enable) m_rem = PW;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        assert (act === exp)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        modelStep();
        @(negedge clk);
        if (rotate && !prev_rot) rises.push_back(cyc);
        if (prev_pr && !pressed) fall_cyc = cyc;
        if (rotate) hi_cnt++;
        prev_rot = rotate;
        prev_pr = pressed;
        checkOutput("rotate", rotate, (m_rem > 0) ? 1 : 0);
        checkOutput("pressed", pressed, m_level);
        checkOutput("repeat_active", repeat_active, m_rep);
    endtask

    task automatic applyStimulus(input logic b, input logic e);
        btn_raw = b;
        enable = e;
        tick();
    endtask

    function automatic int firstRise();
        return (rises.size() > 0) ? rises[0] : -1;
    endfunction

    task automatic startScenario();
        rises.delete();
        hi_cnt = 0;
        fall_cyc = -1;
        k = cyc + 1;
    endtask

    initial begin
        int exp_orient[6];
        exp_orient = '{1, 2, 3, 4, 0, 1};
        modelReset();
        @(negedge clk);
        checkOutput("reset_rotate", rotate, 0);
        checkOutput("reset_pressed", pressed, 0);
        checkOutput("reset_repeat", repeat_active, 0);
        reset = 1'b0;
        repeat (3) applyStimulus(1'b0, 1'b1);

        // Short glitch: never accepted
        startScenario();
        repeat (3) applyStimulus(1'b1, 1'b1);
        repeat (8) applyStimulus(1'b0, 1'b1);
        checkOutput("glitch_strobes", rises.size(), 0);
        checkOutput("glitch_pressed", pressed, 0);

        // Long hold of 40 cycles, then release
        startScenario();
        repeat (40) applyStimulus(1'b1, 1'b1);
        repeat (10) applyStimulus(1'b0, 1'b1);
        checkOutput("hold_count", rises.size(), 7);
        checkOutput("hold_first", firstRise(), k + 6);
        for (int i = 1; i < rises.size(); i++)
            checkOutput("hold_spacing", rises[i] - rises[i-1], (i == 1) ? RD : RP);
        checkOutput("hold_high_cycles", hi_cnt, 7 * PW);
        checkOutput("hold_release", fall_cyc, k + 46);

        // Release bounce: runs of two low/high cycles after an 8-cycle hold
        startScenario();
        repeat (8) applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            repeat (2) applyStimulus(1'b0, 1'b1);
            repeat (2) applyStimulus(1'b1, 1'b1);
        end
        repeat (10) applyStimulus(1'b0, 1'b1);
        checkOutput("bounce_strobes", rises.size(), 1);
        checkOutput("bounce_release", fall_cyc, k + 26);

        // Enable gating: press accepted while disabled, first strobe is the repeat fire
        startScenario();
        repeat (12) applyStimulus(1'b1, 1'b0);
        checkOutput("gate_none_early", rises.size(), 0);
        repeat (5) applyStimulus(1'b1, 1'b1);
        checkOutput("gate_first", firstRise(), k + 16);
        applyStimulus(1'b1, 1'b0);
        checkOutput("gate_tail", rotate, 1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("gate_tail_end", rotate, 0);
        repeat (8) applyStimulus(1'b1, 1'b0);
        checkOutput("gate_suppressed", rises.size(), 1);
        repeat (10) applyStimulus(1'b0, 1'b1);

        // Asynchronous reset in the middle of a strobe with the button held
        repeat (7) applyStimulus(1'b1, 1'b1);
        checkOutput("prereset_rotate", rotate, 1);
        #1 reset = 1'b1;
        #1;
        checkOutput("async_rotate", rotate, 0);
        checkOutput("async_pressed", pressed, 0);
        checkOutput("async_repeat", repeat_active, 0);
        modelReset();
        @(negedge clk);
        reset = 1'b0;
        startScenario();
        repeat (8) applyStimulus(1'b1, 1'b1);
        checkOutput("postreset_first", firstRise(), k + 6);
        repeat (10) applyStimulus(1'b0, 1'b1);

        // Orientation counter driven by six clean presses
        #1 reset = 1'b1;
        modelReset();
        @(negedge clk);
        reset = 1'b0;
        for (int p = 0; p < 6; p++) begin
            repeat (6) applyStimulus(1'b1, 1'b1);
            repeat (10) applyStimulus(1'b0, 1'b1);
            checkOutput("orient", orient, exp_orient[p]);
        end

        // Randomised bouncy presses with random enable
        for (int seg = 0; seg < 40; seg++) begin
            logic lvl;
            int   len;
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 25);
            for (int c = 0; c < len; c++)
                applyStimulus(lvl ^ (($urandom % 8) == 0), ($urandom % 5) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
